// File: rtl/sargantana_icache_pkg.sv
// Shared types and default sizing for the instruction-cache refill path.
// Contents:
//   refill_state_t : refill controller state encoding (2-bit enum)
//   ICACHE_N_WAY   : default associativity
//   LINE_OFF_W     : default byte-offset width within a cache line
package sargantana_icache_pkg;

    localparam int unsigned ICACHE_N_WAY = 4;
    localparam int unsigned LINE_OFF_W   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } refill_state_t;

endpackage

// File: rtl/sargantana_icache_way_pick.sv
// Victim-way selection for a line refill.
// The lowest-index invalid way wins. When every way is valid, the way
// offered by the external LFSR is used and use_random is raised.
// Ports:
//   way_valid  in  N_WAY  valid bits of the indexed set
//   lfsr_way   in  WAY_W  pseudo-random way
//   victim     out WAY_W  selected way
//   use_random out 1      victim came from lfsr_way
module sargantana_icache_way_pick #(
    parameter int unsigned N_WAY = sargantana_icache_pkg::ICACHE_N_WAY,
    localparam int unsigned WAY_W = $clog2(N_WAY)
) (
    input  logic [N_WAY-1:0] way_valid,
    input  logic [WAY_W-1:0] lfsr_way,
    output logic [WAY_W-1:0] victim,
    output logic             use_random
);

    always_comb begin
        use_random = &way_valid;
        victim     = lfsr_way;
        // Scan from the top so that the lowest invalid index is written last.
        for (int i = N_WAY - 1; i >= 0; i--) begin
            if (!way_valid[i]) begin
                victim = WAY_W'(i);
            end
        end
    end

endmodule

// File: rtl/sargantana_icache_refill_ctrl.sv
// Instruction-cache line refill controller.
// Accepts a miss, picks a victim way, issues one line-aligned memory
// request, waits for the single-beat response and pulses the way write.
// A kill aborts the refill; a response already owed by memory is drained.
//
// state | meaning
// IDLE  | no refill in flight, accepting misses
// REQ   | line request presented, waiting for mem_req_ready_i
// WAIT  | request accepted, waiting for the response to write the line
// DRAIN | refill killed, swallowing the outstanding response
//
// Ports:
//   clk_i, rst_ni                     clock, async active-low reset
//   miss_i, miss_addr_i, way_valid_i  miss request from lookup stage
//   kill_i                            flush of the current refill
//   lfsr_way_i, lfsr_en_o             external LFSR value / advance
//   busy_o                            controller not idle
//   mem_req_valid_o/ready_i/addr_o    line request handshake
//   mem_rsp_valid_i                   line data beat
//   refill_we_o, refill_way_o         way write strobe and victim
//   refill_addr_o                     latched miss address
//   done_o                            refill completed pulse
module sargantana_icache_refill_ctrl #(
    parameter int unsigned ICACHE_N_WAY = sargantana_icache_pkg::ICACHE_N_WAY,
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned LINE_OFF_W   = sargantana_icache_pkg::LINE_OFF_W,
    localparam int unsigned WAY_W       = $clog2(ICACHE_N_WAY)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    miss_i,
    input  logic [ADDR_W-1:0]       miss_addr_i,
    input  logic [ICACHE_N_WAY-1:0] way_valid_i,
    input  logic                    kill_i,
    input  logic [WAY_W-1:0]        lfsr_way_i,
    output logic                    lfsr_en_o,
    output logic                    busy_o,
    output logic                    mem_req_valid_o,
    output logic [ADDR_W-1:0]       mem_req_addr_o,
    input  logic                    mem_req_ready_i,
    input  logic                    mem_rsp_valid_i,
    output logic                    refill_we_o,
    output logic [WAY_W-1:0]        refill_way_o,
    output logic [ADDR_W-1:0]       refill_addr_o,
    output logic                    done_o
);

    import sargantana_icache_pkg::*;

    refill_state_t     state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WAY_W-1:0]  way_q, way_d;
    logic              kill_pend_q, kill_pend_d;
    logic [WAY_W-1:0]  pick_victim;
    logic              pick_random;

    sargantana_icache_way_pick #(
        .N_WAY (ICACHE_N_WAY)
    ) u_way_pick (
        .way_valid  (way_valid_i),
        .lfsr_way   (lfsr_way_i),
        .victim     (pick_victim),
        .use_random (pick_random)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            way_q       <= '0;
            kill_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            way_q       <= way_d;
            kill_pend_q <= kill_pend_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        way_d           = way_q;
        kill_pend_d     = kill_pend_q;
        lfsr_en_o       = 1'b0;
        mem_req_valid_o = 1'b0;
        refill_we_o     = 1'b0;
        done_o          = 1'b0;
        case (state_q)
            IDLE: begin
                if (miss_i && !kill_i) begin
                    addr_d      = miss_addr_i;
                    way_d       = pick_victim;
                    kill_pend_d = 1'b0;
                    state_d     = REQ;
                    // IDLE is also the reset state, so a held miss would
                    // otherwise pulse the LFSR while reset is still asserted.
                    lfsr_en_o   = pick_random & rst_ni;
                end
            end
            REQ: begin
                mem_req_valid_o = 1'b1;
                if (kill_i) begin
                    kill_pend_d = 1'b1;
                end
                if (mem_req_ready_i) begin
                    // The request is already accepted, so a kill can only
                    // turn the response into a discard, not cancel it.
                    state_d     = (kill_i || kill_pend_q) ? DRAIN : WAIT;
                    kill_pend_d = 1'b0;
                end
            end
            WAIT: begin
                if (kill_i) begin
                    state_d = mem_rsp_valid_i ? IDLE : DRAIN;
                end else if (mem_rsp_valid_i) begin
                    refill_we_o = 1'b1;
                    done_o      = 1'b1;
                    state_d     = IDLE;
                end
            end
            DRAIN: begin
                if (mem_rsp_valid_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_o         = (state_q != IDLE);
    assign mem_req_addr_o = {addr_q[ADDR_W-1:LINE_OFF_W], {LINE_OFF_W{1'b0}}};
    assign refill_way_o   = way_q;
    assign refill_addr_o  = addr_q;

endmodule

// File: tb/tb_sargantana_icache_refill_ctrl.sv
module tb_sargantana_icache_refill_ctrl;

    localparam int N_WAY  = 4;
    localparam int ADDR_W = 32;
    localparam int WAY_W  = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              miss = 1'b0;
    logic [ADDR_W-1:0] miss_addr = '0;
    logic [N_WAY-1:0]  way_valid = '0;
    logic              kill = 1'b0;
    logic [WAY_W-1:0]  lfsr_way = '0;
    logic              lfsr_en;
    logic              busy;
    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic              req_ready = 1'b0;
    logic              rsp_valid = 1'b0;
    logic              refill_we;
    logic [WAY_W-1:0]  refill_way;
    logic [ADDR_W-1:0] refill_addr;
    logic              done;

    int n_checks = 0;
    int n_fail   = 0;

    int lfsr_cnt, done_cnt, we_cnt, valid_cnt, tot_done;
    logic [ADDR_W-1:0] last_req_addr;

    // Reference model: phase 0 idle, 1 requesting, 2 awaiting data,
    // 3 discarding data after a kill.
    int                m_phase = 0;
    logic [ADDR_W-1:0] m_addr  = '0;
    logic [WAY_W-1:0]  m_way   = '0;
    bit                m_kill_seen = 1'b0;

    always #5 clk = ~clk;

    sargantana_icache_refill_ctrl dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .miss_i          (miss),
        .miss_addr_i     (miss_addr),
        .way_valid_i     (way_valid),
        .kill_i          (kill),
        .lfsr_way_i      (lfsr_way),
        .lfsr_en_o       (lfsr_en),
        .busy_o          (busy),
        .mem_req_valid_o (req_valid),
        .mem_req_addr_o  (req_addr),
        .mem_req_ready_i (req_ready),
        .mem_rsp_valid_i (rsp_valid),
        .refill_we_o     (refill_we),
        .refill_way_o    (refill_way),
        .refill_addr_o   (refill_addr),
        .done_o          (done)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [WAY_W-1:0] ref_victim(input logic [N_WAY-1:0] v, input logic [WAY_W-1:0] l);
        for (int i = 0; i < N_WAY; i++) begin
            if (!v[i]) return WAY_W'(i);
        end
        return l;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0;
            m_addr  = '0;
            m_way   = '0;
            m_kill_seen = 1'b0;
        end else begin
            case (m_phase)
                0: if (miss && !kill) begin
                    m_addr = miss_addr;
                    m_way  = ref_victim(way_valid, lfsr_way);
                    m_kill_seen = 1'b0;
                    m_phase = 1;
                end
                1: begin
                    if (kill) m_kill_seen = 1'b1;
                    if (req_ready) m_phase = m_kill_seen ? 3 : 2;
                end
                2: begin
                    if (kill) m_phase = rsp_valid ? 0 : 3;
                    else if (rsp_valid) m_phase = 0;
                end
                default: if (rsp_valid) m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        logic e_busy, e_valid, e_lfsr, e_we;
        logic [ADDR_W-1:0] e_req_addr, e_raddr;
        logic [WAY_W-1:0]  e_way;
        if (!rst_n) begin
            e_busy = 0; e_valid = 0; e_lfsr = 0; e_we = 0;
            e_req_addr = '0; e_raddr = '0; e_way = '0;
        end else begin
            e_busy     = (m_phase != 0);
            e_valid    = (m_phase == 1);
            e_lfsr     = (m_phase == 0) && miss && !kill && (way_valid == '1);
            e_we       = (m_phase == 2) && rsp_valid && !kill;
            e_req_addr = m_addr & ~32'hF;
            e_raddr    = m_addr;
            e_way      = m_way;
        end
        check("busy", busy, e_busy);
        check("req_valid", req_valid, e_valid);
        if (e_valid || !rst_n) check("req_addr", req_addr, e_req_addr);
        check("lfsr_en", lfsr_en, e_lfsr);
        check("refill_we", refill_we, e_we);
        check("done", done, e_we);
        check("refill_way", refill_way, e_way);
        check("refill_addr", refill_addr, e_raddr);
        if (lfsr_en) lfsr_cnt++;
        if (done) begin done_cnt++; tot_done++; end
        if (refill_we) we_cnt++;
        if (req_valid) begin valid_cnt++; last_req_addr = req_addr; end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        lfsr_cnt = 0; done_cnt = 0; we_cnt = 0; valid_cnt = 0;
        last_req_addr = '0;
    endtask

    initial begin
        clr();
        tot_done = 0;
        #12 rst_n = 1'b1;
        check("rst_busy", busy, 0);
        check("rst_way", refill_way, 0);
        check("rst_addr", refill_addr, 0);
        tick();

        // Lowest invalid way wins, no LFSR use.
        clr();
        way_valid = 4'b1011; miss_addr = 32'h8000_1234; lfsr_way = 2'd1;
        miss = 1; req_ready = 1;
        tick(); tick();
        req_ready = 0;
        tick(); tick();
        rsp_valid = 1;
        tick();
        rsp_valid = 0; miss = 0;
        tick();
        check("t1_way", refill_way, 2);
        check("t1_raddr", refill_addr, 32'h8000_1234);
        check("t1_req_addr", last_req_addr, 32'h8000_1230);
        check("t1_lfsr_cnt", lfsr_cnt, 0);
        check("t1_done_cnt", done_cnt, 1);
        check("t1_we_cnt", we_cnt, 1);

        // All ways valid: random fallback with one LFSR pulse.
        clr();
        way_valid = 4'b1111; lfsr_way = 2'd3; miss_addr = 32'h0000_5678;
        miss = 1; req_ready = 1;
        tick(); tick();
        req_ready = 0; rsp_valid = 1;
        tick();
        rsp_valid = 0; miss = 0;
        tick();
        check("t2_way", refill_way, 3);
        check("t2_lfsr_cnt", lfsr_cnt, 1);
        check("t2_done_cnt", done_cnt, 1);

        // Ready backpressure for five cycles.
        clr();
        way_valid = 4'b0111; lfsr_way = 2'd0; miss_addr = 32'hABCD_EF9F;
        miss = 1; req_ready = 0;
        tick();
        repeat (5) tick();
        req_ready = 1;
        tick();
        req_ready = 0; rsp_valid = 1;
        tick();
        rsp_valid = 0; miss = 0;
        tick();
        check("t3_valid_cycles", valid_cnt, 6);
        check("t3_req_addr", last_req_addr, 32'hABCD_EF90);
        check("t3_way", refill_way, 3);
        check("t3_done_cnt", done_cnt, 1);

        // Kill in WAIT two cycles ahead of the response.
        clr();
        way_valid = 4'b1110; miss_addr = 32'h1111_2222;
        miss = 1; req_ready = 1;
        tick(); tick();
        req_ready = 0; kill = 1; miss = 0;
        tick();
        kill = 0;
        tick();
        check("t4_busy_drain", busy, 1);
        rsp_valid = 1;
        tick();
        rsp_valid = 0;
        check("t4_busy_after", busy, 0);
        check("t4_done_cnt", done_cnt, 0);
        check("t4_we_cnt", we_cnt, 0);

        // Kill and response together in WAIT.
        clr();
        way_valid = 4'b1101; miss_addr = 32'h2222_3333;
        miss = 1; req_ready = 1;
        tick(); tick();
        req_ready = 0;
        tick();
        kill = 1; rsp_valid = 1; miss = 0;
        tick();
        kill = 0; rsp_valid = 0;
        check("t5_busy_after", busy, 0);
        check("t5_done_cnt", done_cnt, 0);
        check("t5_we_cnt", we_cnt, 0);

        // Kill during REQ is remembered and turns the refill into a drain.
        clr();
        way_valid = 4'b0000; miss_addr = 32'h3333_4444;
        miss = 1; req_ready = 0;
        tick();
        kill = 1; miss = 0;
        tick();
        kill = 0; req_ready = 1;
        tick();
        req_ready = 0; rsp_valid = 1;
        tick();
        rsp_valid = 0;
        check("t7_busy_after", busy, 0);
        check("t7_done_cnt", done_cnt, 0);

        // Asynchronous reset mid-REQ with a miss held through it.
        way_valid = 4'b1111; lfsr_way = 2'd2; miss_addr = 32'h4444_5555;
        miss = 1; req_ready = 0;
        tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        check("t6_busy", busy, 0);
        check("t6_req_valid", req_valid, 0);
        check("t6_req_addr", req_addr, 0);
        check("t6_lfsr_en", lfsr_en, 0);
        check("t6_way", refill_way, 0);
        check("t6_raddr", refill_addr, 0);
        tick();
        rst_n = 1'b1;
        clr();
        lfsr_way = 2'd1;
        tick();
        check("t6_accept_busy", busy, 1);
        check("t6_accept_way", refill_way, 1);
        check("t6_lfsr_cnt", lfsr_cnt, 1);
        req_ready = 1;
        tick();
        req_ready = 0; rsp_valid = 1;
        tick();
        rsp_valid = 0; miss = 0;
        tick();
        check("t6_done_cnt", done_cnt, 1);

        // Randomized traffic against the model.
        tot_done = 0;
        repeat (4000) begin
            if (m_phase == 0) begin
                miss      = ($urandom_range(0, 1) == 1);
                miss_addr = $urandom();
                way_valid = ($urandom_range(0, 3) == 0) ? 4'b1111 : 4'($urandom());
            end else begin
                miss = 1;
            end
            lfsr_way  = 2'($urandom());
            kill      = ($urandom_range(0, 9) == 0);
            req_ready = ($urandom_range(0, 1) == 1);
            rsp_valid = (m_phase == 2 || m_phase == 3) && ($urandom_range(0, 9) < 4);
            tick();
        end
        miss = 0; kill = 0; req_ready = 0; rsp_valid = 0;
        tick();
        check("rand_done_seen", (tot_done > 0), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sargantana_icache_refill_ctrl.md
Name: sargantana_icache_refill_ctrl

Overview:
Sequences an instruction-cache line refill after a miss.
- Chooses the victim way: lowest-index invalid way, otherwise the pseudo-random way from the refill LFSR.
- Advances the LFSR only when the random choice is consumed.
- Issues a line-aligned memory request (valid/ready), waits for the response and drives the single-cycle way write.
- Sits between the icache lookup stage and the memory interface; the LFSR is a separate instance fed through lfsr_way_i / lfsr_en_o.

Parameters:
- ICACHE_N_WAY, 4, number of ways; power of two, ≥2.
- ADDR_W, 32, physical fetch address width.
- LINE_OFF_W, 4, byte-offset bits within a line; cleared in the memory request address.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- miss_i  in  1  miss request; level, held by requester until done_o.
- miss_addr_i  in  ADDR_W  missing fetch address; sampled on acceptance.
- way_valid_i  in  ICACHE_N_WAY  valid bits of the indexed set; sampled on acceptance.
- kill_i  in  1  flush/kill of the current refill.
- lfsr_way_i  in  $clog2(ICACHE_N_WAY)  random way from the LFSR.
- lfsr_en_o  out  1  one-cycle LFSR advance.
- busy_o  out  1  controller not in IDLE.
- mem_req_valid_o  out  1  line request valid.
- mem_req_addr_o  out  ADDR_W  line-aligned request address.
- mem_req_ready_i  in  1  memory accepts request.
- mem_rsp_valid_i  in  1  line data valid (one beat).
- refill_we_o  out  1  write line into refill_way_o.
- refill_way_o  out  $clog2(ICACHE_N_WAY)  victim way.
- refill_addr_o  out  ADDR_W  latched miss address for tag/index write.
- done_o  out  1  refill completed and written.

Behaviour:
- States: IDLE, REQ, WAIT, DRAIN; encoded as a 2-bit enum.
- Reset (asynchronous, mid-operation included): state = IDLE; all outputs and registers 0.
- The memory side shares rst_ni, so no response is outstanding after reset.
- IDLE, miss_i=1 and kill_i=0:
  - Latch miss_addr_i.
  - Latch victim = lowest index i with way_valid_i[i]=0.
  - If all ways are valid, victim = lfsr_way_i and lfsr_en_o=1 in this cycle only.
  - Next state REQ.
- IDLE, miss_i=1 and kill_i=1: miss ignored, stay IDLE, lfsr_en_o=0.
- REQ:
  - mem_req_valid_o=1; mem_req_addr_o = latched address with [LINE_OFF_W-1:0] = 0.
  - Address held stable until handshake; the request is never withdrawn.
  - On mem_req_ready_i: go to WAIT, or to DRAIN if kill_i is seen now or was latched earlier in REQ.
  - kill_i in REQ sets a kill_pend flag.
- WAIT:
  - mem_rsp_valid_i=1 and kill_i=0: refill_we_o=1 and done_o=1 in the same cycle (combinational from rsp), then IDLE.
  - kill_i=1 without rsp: go to DRAIN.
  - kill_i=1 with rsp in the same cycle: kill wins; refill_we_o=0, done_o=0, go to IDLE.
- DRAIN: wait for mem_rsp_valid_i; consume it with refill_we_o=0 and done_o=0, then IDLE. kill_i ignored here.
- busy_o = (state != IDLE), registered-state decode.
- refill_way_o and refill_addr_o:
  - Registered.
  - Hold the latched values from acceptance until the next acceptance.
- miss_i while busy: ignored; the requester keeps it asserted.
- done_o is a one-cycle pulse.
- miss_i still high in the cycle after done_o starts a new refill: legal, back-to-back.
- lfsr_en_o is never asserted outside the IDLE acceptance cycle; at most one pulse per refill.

Decomposition:
- Package sargantana_icache_pkg holds:
  - refill_state_t enum (IDLE, REQ, WAIT, DRAIN).
  - Default constants ICACHE_N_WAY=4 and LINE_OFF_W=4.
- One natural sub-module: sargantana_icache_way_pick.
  - Purely combinational.
  - Inputs: way_valid, lfsr_way. Outputs: victim, use_random.
  - Implements the lowest-invalid-way priority encoder with random fallback.
- The LFSR stays external, instantiated by the icache top.

Test Plan:
- Invalid-way priority: way_valid_i=4'b1011, miss_addr_i=0x8000_1234; ready immediately; rsp 3 cycles later.
  - Expect refill_way_o=2 and lfsr_en_o never high.
  - Expect mem_req_addr_o=0x8000_1230 and one refill_we_o/done_o pulse in the rsp cycle.
- Random fallback: way_valid_i=4'b1111, lfsr_way_i=3.
  - Expect refill_way_o=3 and exactly one lfsr_en_o pulse in the acceptance cycle.
- Ready backpressure: hold mem_req_ready_i=0 for 5 cycles.
  - Expect mem_req_valid_o=1 with the address stable for all 6 cycles, then WAIT.
- Kill in WAIT: assert kill_i two cycles before rsp.
  - Expect DRAIN, refill_we_o=0 and done_o=0 at rsp, then busy_o=0 the next cycle.
- Simultaneous kill and rsp in WAIT: expect no write, no done, IDLE the next cycle.
- Reset mid-REQ: deassert rst_ni asynchronously.
  - Expect all outputs 0 immediately and IDLE after release.
  - A miss held high during reset is accepted on the first clock after release.
